ln_stats_engine: RTL and testbench

LN_STATS_ENGINE -- requirements
Module: ln_stats_engine

---
 rtl/npu_pkg.sv | 19 +
 rtl/ln_var_calc.sv | 41 ++++
 rtl/ln_stats_engine.sv | 141 ++++++++++++++
 tb/tb_ln_stats_engine.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared types and constants for the layer-norm statistics engine.
package npu_pkg;

  localparam int LN_MAX_LOG2 = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_CALC,
    ST_LUT_WAIT,
    ST_CAPTURE,
    ST_DONE
  } ln_state_e;

  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    return (l > 4'(LN_MAX_LOG2)) ? 4'(LN_MAX_LOG2) : l;
  endfunction

endpackage

// File: rtl/ln_var_calc.sv
// Combinational mean/variance from running sums: floor mean, E[x^2] - mean^2 clamped at zero.
module ln_var_calc
  import npu_pkg::*;
(
  input  logic signed [16:0] sum_i,
  input  logic        [22:0] sumsq_i,
  input  logic        [3:0]  len_log2_i,
  output logic signed [7:0]  mean_o,
  output logic        [15:0] var_o
);

  logic signed [16:0] mean_full;
  logic        [22:0] ex2;
  logic signed [15:0] mean_ext;
  logic        [15:0] mean_sq;
  logic        [23:0] diff;

  always_comb begin
    mean_full = sum_i >>> len_log2_i;
    // The average of int8 samples always fits; saturation only guards the width.
    if (mean_full > 17'sd127) begin
      mean_o = 8'sd127;
    end else if (mean_full < -17'sd128) begin
      mean_o = -8'sd128;
    end else begin
      mean_o = mean_full[7:0];
    end
    ex2      = sumsq_i >> len_log2_i;
    mean_ext = {{8{mean_o[7]}}, mean_o};
    mean_sq  = mean_ext * mean_ext;
    diff     = {1'b0, ex2} - {8'd0, mean_sq};
    if (diff[23]) begin
      var_o = '0;
    end else if (|diff[22:16]) begin
      var_o = '1;
    end else begin
      var_o = diff[15:0];
    end
  end

endmodule

// File: rtl/ln_stats_engine.sv
// Streams 2^len_log2 int8 elements, then reports mean, variance and 1/sqrt(var) from an external ROM.
module ln_stats_engine
  import npu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  len_log2,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [7:0]  lut_addr,
  input  logic [15:0] lut_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_mean,
  output logic [15:0] out_var,
  output logic [15:0] out_rsqrt,
  output logic        busy
);

  ln_state_e          state_q, state_d;
  logic        [3:0]  len_q, len_d;
  logic signed [16:0] sum_q, sum_d;
  logic        [22:0] sumsq_q, sumsq_d;
  logic        [8:0]  count_q, count_d;
  logic        [7:0]  mean_q, mean_d;
  logic        [15:0] var_q, var_d;
  logic        [7:0]  addr_q, addr_d;
  logic        [15:0] rsqrt_q, rsqrt_d;

  logic        [7:0]  calc_mean;
  logic        [15:0] calc_var;
  logic        [8:0]  target;
  logic signed [15:0] din_ext;
  logic        [15:0] din_sq;

  ln_var_calc u_calc (
    .sum_i      (sum_q),
    .sumsq_i    (sumsq_q),
    .len_log2_i (len_q),
    .mean_o     (calc_mean),
    .var_o      (calc_var)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    sumsq_d = sumsq_q;
    count_d = count_q;
    mean_d  = mean_q;
    var_d   = var_q;
    addr_d  = addr_q;
    rsqrt_d = rsqrt_q;
    target  = 9'd1 << len_q;
    din_ext = {{8{in_data[7]}}, in_data};
    din_sq  = din_ext * din_ext;

    if (abort) begin
      state_d = ST_IDLE;
      sum_d   = '0;
      sumsq_d = '0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_d   = clamp_len(len_log2);
            sum_d   = '0;
            sumsq_d = '0;
            count_d = '0;
            state_d = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            sum_d   = sum_q + {{9{in_data[7]}}, in_data};
            sumsq_d = sumsq_q + {7'd0, din_sq};
            count_d = count_q + 9'd1;
            if (count_q + 9'd1 == target) begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          mean_d  = calc_mean;
          var_d   = calc_var;
          addr_d  = calc_var[15:8];
          state_d = ST_LUT_WAIT;
        end
        // ROM samples the held address on this edge; data is ready for CAPTURE.
        ST_LUT_WAIT: state_d = ST_CAPTURE;
        ST_CAPTURE: begin
          rsqrt_d = lut_data;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      sum_q   <= '0;
      sumsq_q <= '0;
      count_q <= '0;
      mean_q  <= '0;
      var_q   <= '0;
      addr_q  <= '0;
      rsqrt_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      sumsq_q <= sumsq_d;
      count_q <= count_d;
      mean_q  <= mean_d;
      var_q   <= var_d;
      addr_q  <= addr_d;
      rsqrt_q <= rsqrt_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_mean  = mean_q;
  assign out_var   = var_q;
  assign out_rsqrt = rsqrt_q;
  assign lut_addr  = addr_q;

endmodule

// File: tb/tb_ln_stats_engine.sv
// Randomised scoreboard bench for ln_stats_engine with a registered 1/sqrt ROM model.
module tb_ln_stats_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  len_log2;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [7:0]  lut_addr;
  logic [15:0] lut_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_mean;
  logic [15:0] out_var;
  logic [15:0] out_rsqrt;
  logic        busy;

  ln_stats_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len_log2  (len_log2),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mean  (out_mean),
    .out_var   (out_var),
    .out_rsqrt (out_rsqrt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mean;
    int var_v;
    int rsqrt;
  } exp_t;

  exp_t        sb[$];
  int          rom[256];
  int          vec[256];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_acc = 0;
  logic        prev_ov = 1'b0;
  logic [39:0] cap;

  initial begin
    rom[0] = 16'hFFFF;
    for (int i = 1; i < 256; i++) rom[i] = int'(4096.0 / $sqrt(real'(i)));
  end

  always @(posedge clk) lut_data <= 16'(rom[lut_addr]);
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference: floor mean, integer E[x^2], variance clamped at zero, ROM lookup on var/256.
  function automatic exp_t model(input int k_in);
    exp_t e;
    int k, n, s, sq, ex2;
    k  = (k_in > 8) ? 8 : k_in;
    n  = 1 << k;
    s  = 0;
    sq = 0;
    for (int i = 0; i < n; i++) begin
      s  += vec[i];
      sq += vec[i] * vec[i];
    end
    e.mean  = (s >= 0) ? s / n : -((-s + n - 1) / n);
    ex2     = sq / n;
    e.var_v = ex2 - e.mean * e.mean;
    if (e.var_v < 0) e.var_v = 0;
    e.rsqrt = rom[(e.var_v / 256) % 256];
    return e;
  endfunction

  function automatic exp_t mk(input int m, input int v, input int r);
    exp_t e;
    e.mean = m; e.var_v = v; e.rsqrt = r;
    return e;
  endfunction

  // Monitor: latency, hold stability and scoreboard pops, all sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready && !abort) last_acc = cyc + 1;
      if (out_valid && !prev_ov) begin
        chk("latency", cyc - last_acc, 3);
        cap = {out_mean, out_var, out_rsqrt};
      end else if (out_valid) begin
        chk("hold_stable", int'({out_mean, out_var, out_rsqrt} == cap), 1);
        chk("busy_in_done", int'(busy), 1);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("mean", int'($signed(out_mean)), e.mean);
          chk("var", int'(out_var), e.var_v);
          chk("lut_addr", int'(lut_addr), (e.var_v / 256) % 256);
          chk("rsqrt", int'(out_rsqrt), e.rsqrt);
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input int gap);
    int   n, i, guard;
    logic v, r;
    n = 1 << ((k > 8) ? 8 : k);
    start = 1'b1; len_log2 = 4'(k);
    tick();
    start = 1'b0;
    i = 0; guard = 0;
    while (i < n && guard < 5000) begin
      v = ($urandom_range(99) >= gap);
      in_valid = v;
      in_data  = 8'(vec[i]);
      r = in_ready;
      tick();
      if (v && r) i++;
      guard++;
    end
    in_valid = 1'b0;
    if (i < n) chk("send_timeout", i, n);
  endtask

  task automatic take(input int hold, input logic start_meanwhile);
    int guard;
    guard = 0;
    while (!out_valid && guard < 50) begin
      tick();
      guard++;
    end
    chk("out_valid_seen", int'(out_valid), 1);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start = start_meanwhile;
      tick();
      chk("busy_hold", int'(busy), 1);
    end
    start = start_meanwhile;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    chk("idle_after_hs", int'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; len_log2 = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_outs", int'({out_mean, out_var, out_rsqrt, lut_addr}), 0);
    rst_n = 1'b1;
    tick();

    vec[0] = 0; vec[1] = 64;
    sb.push_back(mk(32, 1024, 2048));
    send(1, 0); take(0, 1'b0);

    for (int i = 0; i < 4; i++) vec[i] = 4;
    sb.push_back(mk(4, 0, 16'hFFFF));
    send(2, 30); take(0, 1'b0);

    vec[0] = -1; vec[1] = 0;
    sb.push_back(mk(-1, 0, 16'hFFFF));
    send(1, 0); take(0, 1'b0);

    for (int i = 0; i < 256; i++) vec[i] = -128;
    sb.push_back(mk(-128, 0, 16'hFFFF));
    send(8, 40); take(0, 1'b0);

    // Abort mid-accumulation, with start and a valid element in the same cycle.
    for (int i = 0; i < 4; i++) vec[i] = int'($urandom_range(255)) - 128;
    start = 1'b1; len_log2 = 4'd2; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'(vec[0]); tick();
    abort = 1'b1; start = 1'b1; tick();
    abort = 1'b0; start = 1'b0; in_valid = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    vec[0] = 0; vec[1] = 64;
    sb.push_back(mk(32, 1024, 2048));
    send(1, 0); take(0, 1'b0);

    for (int i = 0; i < 8; i++) vec[i] = int'($urandom_range(255)) - 128;
    sb.push_back(model(3));
    send(3, 20); take(10, 1'b1);

    vec[0] = int'($urandom_range(255)) - 128;
    sb.push_back(mk(vec[0], 0, 16'hFFFF));
    send(0, 0); take(0, 1'b0);

    // Reset in the middle of a pass: nothing may come out of it.
    start = 1'b1; len_log2 = 4'd3; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'd17; tick(); tick();
    in_valid = 1'b0; rst_n = 1'b0; #2;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    tick(); rst_n = 1'b1; tick();

    for (int p = 0; p < 25; p++) begin
      int k;
      k = int'($urandom_range(15));
      for (int i = 0; i < 256; i++) vec[i] = int'($urandom_range(255)) - 128;
      if (p % 5 == 0) for (int i = 0; i < 256; i++) vec[i] = (i % 2 == 0) ? 127 : -128;
      sb.push_back(model(k));
      send(k, int'($urandom_range(50)));
      take(int'($urandom_range(3)), 1'(p % 2));
    end

    repeat (5) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
